// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin select arbiter.
// Holds the FSM state encoding and the requester/index widths.
package rr_sel_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request scanning circularly from ptr.
// Rotates req so ptr lands on bit 0, priority-encodes, then adds ptr back mod 8.
module rr_pick8
    import rr_sel_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] dbl_shift;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    always_comb begin
        dbl       = {req, req};
        dbl_shift = dbl >> ptr;
        // rot[k] is req[(ptr + k) mod 8]
        rot       = dbl_shift[NUM_REQ-1:0];
        off       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
            end
        end
        found = |req;
        idx   = ptr + off;
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a registered 3-bit select into a 3-to-8 decoder.
// A grant is held until done, request drop, or MAX_HOLD cycles have elapsed.
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               sel_a,
    output logic               sel_b,
    output logic               sel_c,
    output logic               grant_valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gv_q, gv_d;
    logic               to_q, to_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               rel_done, rel_drop, rel_hold, release_now;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gv_d        = gv_q;
        to_d        = 1'b0;
        rel_done    = done;
        rel_drop    = !req[idx_q];
        rel_hold    = (cnt_q == HOLD_LAST);
        release_now = rel_done || rel_drop || rel_hold;

        case (state_q)
            IDLE: begin
                gv_d = 1'b0;
                if (pick_found) begin
                    state_d = BUSY;
                    idx_d   = pick_idx;
                    gv_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d = IDLE;
                    gv_d    = 1'b0;
                    ptr_d   = idx_q + IDX_W'(1);
                    // Only a pure hold expiry counts as a forced release
                    to_d    = !rel_done && !rel_drop;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gv_q    <= gv_d;
            to_q    <= to_d;
        end
    end

    assign sel_a       = idx_q[2];
    assign sel_b       = idx_q[1];
    assign sel_c       = idx_q[0];
    assign grant_valid = gv_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed scenarios plus a randomized
// run scored against a cycle-level reference model through an expected queue.
module tb_rr_sel_arbiter;
    import rr_sel_arbiter_pkg::*;

    localparam int MAX_HOLD = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       done  = 1'b0;
    logic [7:0] req1  = 8'h00;
    logic       done1 = 1'b0;
    logic       sel_a, sel_b, sel_c, grant_valid, timeout;
    logic       s1_a, s1_b, s1_c, gv1, to1;
    logic [2:0] sel, sel1;
    logic [7:0] dec;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];
    logic [2:0] fair_q[$];

    logic       m_busy;
    logic [2:0] m_idx, m_ptr;
    int         m_cnt;
    logic       m_gv, m_to;

    rr_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c),
        .grant_valid(grant_valid), .timeout(timeout)
    );

    rr_sel_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .done(done1),
        .sel_a(s1_a), .sel_b(s1_b), .sel_c(s1_c),
        .grant_valid(gv1), .timeout(to1)
    );

    assign sel  = {sel_a, sel_b, sel_c};
    assign sel1 = {s1_a, s1_b, s1_c};
    // Reference 3-to-8 one-hot decoder fed by the arbiter select lines
    assign dec  = 8'd1 << sel;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({sel, grant_valid, timeout} !== 5'b000_0_0) begin
            errors++;
            $display("FAIL reset_init: got sel=%b gv=%b to=%b, want 000 0 0", sel, grant_valid, timeout);
        end
        tick();
        rst_n = 1'b1;
        req = 8'h20;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || sel !== 3'd5) begin
            errors++;
            $display("FAIL reset_pregrant: got gv=%b sel=%0d, want 1 5", grant_valid, sel);
        end
        req = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, grant_valid, timeout} !== 5'b000_0_0) begin
            errors++;
            $display("FAIL reset_async: got sel=%b gv=%b to=%b, want 000 0 0", sel, grant_valid, timeout);
        end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req = 8'h08;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || sel !== 3'b011 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL single_hold[%0d]: got gv=%b sel=%b to=%b, want 1 011 0", c, grant_valid, sel, timeout);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0 || sel !== 3'b011) begin
            errors++;
            $display("FAIL single_release: got gv=%b to=%b sel=%b, want 0 0 011", grant_valid, timeout, sel);
        end
        req = 8'h11;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || sel !== 3'd4) begin
            errors++;
            $display("FAIL single_ptr4: got gv=%b sel=%0d, want 1 4", grant_valid, sel);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_fairness();
        pulse_reset();
        for (int i = 0; i < 8; i++) fair_q.push_back(3'(i));
        fair_q.push_back(3'd0);
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            tick();
            checks++;
            if (fair_q.size() == 0) begin
                errors++;
                $display("FAIL fair_queue_empty: got empty queue at grant %0d, want entry", n);
            end else begin
                logic [2:0] e;
                e = fair_q.pop_front();
                if (grant_valid !== 1'b1 || sel !== e) begin
                    errors++;
                    $display("FAIL fair_grant[%0d]: got gv=%b idx=%0d, want 1 %0d", n, grant_valid, sel, e);
                end
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL fair_bubble[%0d]: got gv=%b, want 0", n, grant_valid);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        req = 8'h40;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || sel !== 3'd6 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: got gv=%b sel=%0d to=%b, want 1 6 0", c, grant_valid, sel, timeout);
            end
        end
        tick();
        if (timeout === 1'b1) pulses++;
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: got gv=%b to=%b, want 0 1", grant_valid, timeout);
        end
        tick();
        if (timeout === 1'b1) pulses++;
        checks++;
        if (grant_valid !== 1'b1 || sel !== 3'd6 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: got gv=%b sel=%0d to=%b, want 1 6 0", grant_valid, sel, timeout);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL timeout_pulse_count: got %0d, want 1", pulses);
        end
        req = 8'h00;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop: got gv=%b to=%b, want 0 0", grant_valid, timeout);
        end
    endtask

    task automatic test_drop();
        req = 8'h04;
        tick();
        req = 8'h05;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || sel !== 3'd2) begin
                errors++;
                $display("FAIL drop_hold[%0d]: got gv=%b sel=%0d, want 1 2", c, grant_valid, sel);
            end
        end
        req = 8'h03;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: got gv=%b to=%b, want 0 0", grant_valid, timeout);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || sel !== 3'd0) begin
            errors++;
            $display("FAIL drop_wrap: got gv=%b sel=%0d, want 1 0", grant_valid, sel);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || sel !== 3'd1) begin
            errors++;
            $display("FAIL drop_next: got gv=%b sel=%0d, want 1 1", grant_valid, sel);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_decoder();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] onehot;
            onehot = 8'd1 << i;
            req = onehot;
            tick();
            checks++;
            if (grant_valid !== 1'b1 || dec !== onehot) begin
                errors++;
                $display("FAIL decoder[%0d]: got gv=%b dec=%b, want 1 %b", i, grant_valid, dec, onehot);
            end
            done = 1'b1;
            req = 8'h00;
            tick();
            done = 1'b0;
        end
    endtask

    task automatic test_hold1();
        req1 = 8'h10;
        tick();
        checks++;
        if (gv1 !== 1'b1 || sel1 !== 3'd4 || to1 !== 1'b0) begin
            errors++;
            $display("FAIL hold1_grant: got gv=%b sel=%0d to=%b, want 1 4 0", gv1, sel1, to1);
        end
        tick();
        checks++;
        if (gv1 !== 1'b0 || to1 !== 1'b1) begin
            errors++;
            $display("FAIL hold1_timeout: got gv=%b to=%b, want 0 1", gv1, to1);
        end
        tick();
        checks++;
        if (gv1 !== 1'b1 || to1 !== 1'b0) begin
            errors++;
            $display("FAIL hold1_regrant: got gv=%b to=%b, want 1 0", gv1, to1);
        end
        done1 = 1'b1;
        tick();
        checks++;
        if (gv1 !== 1'b0 || to1 !== 1'b0) begin
            errors++;
            $display("FAIL hold1_done: got gv=%b to=%b, want 0 0", gv1, to1);
        end
        done1 = 1'b0;
        req1 = 8'h00;
        tick();
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        logic       found;
        logic [2:0] pos;
        m_to = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                pos = m_ptr + 3'(k);
                if (!found && r[pos]) begin
                    found = 1'b1;
                    m_idx = pos;
                end
            end
            m_gv = found;
            if (found) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (d || !r[m_idx] || m_cnt == MAX_HOLD - 1) begin
            m_to   = !d && r[m_idx];
            m_gv   = 1'b0;
            m_busy = 1'b0;
            m_ptr  = m_idx + 3'd1;
        end else begin
            m_cnt++;
        end
        exp_q.push_back({m_idx, m_gv, m_to});
    endtask

    task automatic test_random();
        logic [4:0] got, e;
        pulse_reset();
        m_busy = 1'b0; m_idx = '0; m_ptr = '0; m_cnt = 0; m_gv = 1'b0; m_to = 1'b0;
        req = 8'h00;
        done = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) req = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            done = ($urandom_range(0, 11) == 0);
            model_step(req, done);
            tick();
            got = {sel, grant_valid, timeout};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rand_queue_empty[%0d]: got empty queue, want entry", n);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL rand[%0d]: got sel/gv/to=%b, want %b (req=%h done=%b)", n, got, e, req, done);
                end
            end
        end
        req = 8'h00;
        done = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_drop();
        test_decoder();
        test_hold1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got simulation time limit, want completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- 8-requester round-robin arbiter producing the registered 3-bit select {sel_a, sel_b, sel_c} consumed directly by the downstream 3-to-8 one-hot decoder.
- Holds a grant until the owner signals done, drops its request, or a hold timeout expires.
- The rotating priority pointer guarantees no requester waits more than 7 other grants.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant is held before forced release; legal range 1..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i.
- done  input  1  current grant owner releases; sampled only while grant_valid=1.
- sel_a  output  1  select MSB (idx[2]) to decoder.
- sel_b  output  1  select idx[1].
- sel_c  output  1  select LSB (idx[0]).
- grant_valid  output  1  high while a grant is active; the decoder output is meaningful only when this is high.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, {sel_a,sel_b,sel_c}=3'b000, grant_valid=0, timeout=0, ptr=0, hold_cnt=0.
- All outputs are registered; no combinational path from req/done to outputs.
- States:
  - IDLE: if req != 0, choose the first set bit scanning circularly from ptr upward (ptr, ptr+1, ... mod 8). Register idx, set grant_valid=1, hold_cnt=0, go to BUSY. Grant appears the cycle after req is sampled (1-cycle latency). If req == 0, stay in IDLE with outputs unchanged and grant_valid=0.
  - BUSY: hold_cnt increments each cycle (saturates at MAX_HOLD-1). Release conditions, evaluated in priority order:
    1. done=1
    2. req[idx]=0
    3. hold_cnt == MAX_HOLD-1
  - On release: grant_valid=0 the next cycle, ptr=idx+1 (mod 8, 3-bit wrap 7->0), state=IDLE. timeout=1 for exactly that cycle only when release cause 3 applied alone, i.e. done=0 and req[idx]=1.
- Select lines keep the last idx after release (not cleared); consumers qualify with grant_valid.
- Minimum one-cycle grant_valid=0 bubble between consecutive grants, including back-to-back requests from the same requester.
- MAX_HOLD=1: a grant lasts exactly 1 cycle; timeout pulses on release unless done=1 or req[idx]=0 in that cycle.
- done or req changes while in IDLE are ignored. Requests arriving in BUSY wait; they do not preempt the current grant.
- Reset asserted mid-grant: immediate async clear to reset values; the pointer returns to 0.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, BUSY=1'b1), NUM_REQ=8, IDX_W=3.
- One natural sub-module: rr_pick8. Purely combinational; inputs req[7:0] and ptr[2:0], outputs found and idx[2:0]; implemented as rotate, priority-encode, add ptr back mod 8.
- The FSM, hold counter and output registers live in the top module.

Test Plan:
- Reset check: assert rst_n=0 mid-BUSY with idx=5 -> sel=000, grant_valid=0, timeout=0 immediately, without waiting for a clk edge.
- Single requester: req=8'b0000_1000, done pulsed 3 cycles after grant -> sel=011, grant_valid high for 4 cycles, then 0; ptr=4; timeout stays 0.
- Fairness: req=8'hFF held, done pulsed the cycle after each grant -> grant idx sequence 0,1,2,...,7,0 with a 1-cycle bubble between grants.
- Timeout: MAX_HOLD=16, req=8'h40 held, done=0 -> grant idx=6 for 16 cycles, timeout pulses once on the release cycle, regrant to 6 after a 1-cycle bubble.
- Request drop: grant to idx=2, req[2] deasserted after 5 cycles -> grant_valid falls next cycle, no timeout; with req=8'h05 pending, next grant is idx=0 after wrap (ptr=3 scans 3..7 then 0).
- Decoder hookup: drive the arbiter into a real decoder instance -> decoder output equals 1<<idx whenever grant_valid=1 for all 8 indices.
